byte_bus_adapter: RTL and testbench
===================================

BYTE_BUS_ADAPTER -- requirements
Module: byte_bus_adapter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: the number of ack-wait cycles before a timeout fault; used only when BYTE_BUS_ACK_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1: request is valid and held by the core for as long as busy is high.
REQ-005 SHALL have port is_write, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port is_unsigned, input, 1: 1 = zero-extend a load, 0 = sign-extend a load.
REQ-007 SHALL have port size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = invalid.
REQ-008 SHALL have port addr, input, 32: byte address.
REQ-009 SHALL have port data_in, input, 32: store data; low bytes are used for byte and half stores.
REQ-010 SHALL have port data_out, output, 32: load result.
REQ-011 SHALL have port busy, output, 1: the access is incomplete; the stage must not advance.
REQ-012 SHALL have ports op_fault, addr_fault and access_fault, each output, 1: each is a one-cycle fault pulse.
REQ-013 SHALL have port ext_addr, output, 32: external byte address.
REQ-014 SHALL have port ext_wdata, output, 8: external write byte.
REQ-015 SHALL have ports ext_req and ext_we, each output, 1: external request strobe and external write enable.
REQ-016 SHALL have port ext_rdata, input, 8: external read byte.
REQ-017 SHALL have ports ext_ack and ext_err, each input, 1: completion and bus-error for the current byte; both are sampled at the rising edge while ext_req is high.

Function
REQ-018 SHALL implement the states IDLE, XFER and DONE.
REQ-019 In IDLE with enable=1, the block SHALL drive busy combinationally high and SHALL capture the request (is_write, is_unsigned, size, addr, data_in) at the rising edge.
REQ-020 IDLE -> DONE SHALL occur when size=11; op_fault SHALL be set and no ext_req SHALL be issued.
REQ-021 IDLE -> DONE SHALL occur on misalignment (half with addr[0]=1, or word with addr[1:0]!=0); addr_fault SHALL be set and no ext_req SHALL be issued.
REQ-022 For all other requests, IDLE -> XFER SHALL occur with byte index idx=0 and byte count N = 1, 2 or 4 for byte, half or word respectively.
REQ-023 In XFER, the block SHALL drive ext_req=1, ext_we=is_write, ext_addr=addr+idx and ext_wdata=data_in[8*idx+7:8*idx] (little-endian).
REQ-024 When ext_ack=1 at an edge in XFER, a load SHALL store ext_rdata into byte idx of the result, and idx SHALL increment.
REQ-025 When ext_ack=1 at an edge with idx=N-1, the block SHALL go to DONE.
REQ-026 A slave that acks in the same cycle it sees ext_req SHALL give a word latency of 4 XFER cycles.
REQ-027 When ext_err=1 in XFER, the block SHALL go to DONE with access_fault set and SHALL NOT request the remaining bytes; ext_err SHALL take priority over a simultaneous ext_ack.
REQ-028 In DONE, busy SHALL be 0 and ext_req SHALL be 0; fault outputs SHALL be high only during this single cycle.
REQ-029 DONE SHALL go to IDLE unconditionally.
REQ-030 A new request SHALL NOT be accepted in DONE; one idle cycle always separates accesses.
REQ-031 On a successful load, data_out SHALL be updated entering DONE: sign- or zero-extended from bit 7 for byte loads and from bit 15 for half loads.
REQ-032 data_out SHALL otherwise hold its value: unchanged by stores and by faulted accesses.
REQ-033 If enable falls in XFER, the block SHALL abort to IDLE at the next edge with no fault, and ext_req SHALL be 0 from that edge.
REQ-034 addr+idx SHALL wrap modulo 2^32.

Reset
REQ-035 reset=1 SHALL force IDLE and set idx=0, busy=0, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, data_out=0 and all fault outputs=0, overriding every other input, including mid-XFER.
REQ-036 The first request after reset deassertion SHALL be accepted in the cycle reset is low.

Configuration
REQ-037 With BYTE_BUS_ACK_TIMEOUT_EN defined, a wait counter SHALL clear at each byte start and count XFER cycles without ack or err.
REQ-038 With BYTE_BUS_ACK_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL go to DONE with access_fault set.
REQ-039 Without BYTE_BUS_ACK_TIMEOUT_EN, the block SHALL contain no counter and SHALL wait for ack or err indefinitely.

Verification
REQ-040 Word load, addr=0x100, bytes 0x78,0x56,0x34,0xF2, zero-wait ack -> 4 XFER cycles, ext_addr 0x100..0x103, data_out=0xF2345678, no fault.
REQ-041 Byte load signed/unsigned, addr=0x7, ext_rdata=0x80 -> data_out=0xFFFFFF80 with is_unsigned=0, 0x00000080 with is_unsigned=1.
REQ-042 Half store, addr=0x202, data_in=0xAABBCCDD -> ext_wdata 0xDD@0x202 then 0xCC@0x203 with ext_we=1; data_out unchanged.
REQ-043 Word load at addr=0x102 -> addr_fault one-cycle pulse, zero ext_req cycles; size=11 -> op_fault pulse.
REQ-044 Word load with ext_err on the byte 1 request -> access_fault pulse, no request for 0x102; reset asserted mid-XFER -> ext_req=0 and busy=0 the next cycle.
REQ-045 With BYTE_BUS_ACK_TIMEOUT_EN defined, ack held low -> access_fault after exactly 16 XFER cycles; without the macro, busy stays high for 100+ cycles.

Source files
------------

// File: rtl/byte_bus_adapter.sv
// byte_bus_adapter: serialises byte/half/word loads and stores onto an 8-bit req/ack bus, little-endian.
// Optional ack-wait timeout fault is built only when BYTE_BUS_ACK_TIMEOUT_EN is defined.
module byte_bus_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        is_write,
  input  logic        is_unsigned,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        op_fault,
  output logic        addr_fault,
  output logic        access_fault,
  output logic [31:0] ext_addr,
  output logic [7:0]  ext_wdata,
  output logic        ext_req,
  output logic        ext_we,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  input  logic        ext_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("byte_bus_adapter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state, state_next;
  logic [1:0]  idx, idx_inc, last_idx;
  logic        req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] rbuf, load_word, load_ext;

  logic capture, start_xfer, advance, finish_ok;
  logic set_op, set_addr, set_acc;
  logic misaligned, timeout_hit;

  assign misaligned = ((size == SIZE_HALF) && addr[0]) ||
                      ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
  assign last_idx   = (req_size == SIZE_BYTE) ? 2'd0 :
                      (req_size == SIZE_HALF) ? 2'd1 : 2'd3;
  assign idx_inc    = idx + 2'd1;

  // busy is combinational so the core stalls in the very cycle it presents a request
  assign busy = !reset && ((state == XFER) || ((state == IDLE) && enable));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state and per-cycle control strobes
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    start_xfer = 1'b0;
    advance    = 1'b0;
    finish_ok  = 1'b0;
    set_op     = 1'b0;
    set_addr   = 1'b0;
    set_acc    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          capture = 1'b1;
          if (size == SIZE_BAD) begin
            state_next = DONE;
            set_op     = 1'b1;
          end else if (misaligned) begin
            state_next = DONE;
            set_addr   = 1'b1;
          end else begin
            state_next = XFER;
            start_xfer = 1'b1;
          end
        end
      end
      XFER: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (ext_err) begin
          state_next = DONE;
          set_acc    = 1'b1;
        end else if (ext_ack) begin
          if (idx == last_idx) begin
            state_next = DONE;
            finish_ok  = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next = DONE;
          set_acc    = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // merge the incoming byte into the load buffer, then extend to 32 bits
  always_comb begin
    load_word = rbuf;
    load_word[{idx, 3'b000} +: 8] = ext_rdata;
  end

  always_comb begin
    case (req_size)
      SIZE_BYTE: load_ext = {{24{~req_unsigned & load_word[7]}}, load_word[7:0]};
      SIZE_HALF: load_ext = {{16{~req_unsigned & load_word[15]}}, load_word[15:0]};
      default:   load_ext = load_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx          <= 2'd0;
      req_write    <= 1'b0;
      req_unsigned <= 1'b0;
      req_size     <= 2'b00;
      req_addr     <= 32'd0;
      req_wdata    <= 32'd0;
      rbuf         <= 32'd0;
      data_out     <= 32'd0;
      op_fault     <= 1'b0;
      addr_fault   <= 1'b0;
      access_fault <= 1'b0;
      ext_req      <= 1'b0;
      ext_we       <= 1'b0;
      ext_addr     <= 32'd0;
      ext_wdata    <= 8'd0;
    end else begin
      op_fault     <= set_op;
      addr_fault   <= set_addr;
      access_fault <= set_acc;
      if (capture) begin
        req_write    <= is_write;
        req_unsigned <= is_unsigned;
        req_size     <= size;
        req_addr     <= addr;
        req_wdata    <= data_in;
      end
      // bus outputs are loaded for the byte about to be presented
      if (start_xfer) begin
        idx       <= 2'd0;
        ext_req   <= 1'b1;
        ext_we    <= is_write;
        ext_addr  <= addr;
        ext_wdata <= data_in[7:0];
      end else if (advance) begin
        idx       <= idx_inc;
        ext_addr  <= req_addr + 32'(idx_inc);
        ext_wdata <= 8'(req_wdata >> {idx_inc, 3'b000});
        if (!req_write) rbuf <= load_word;
      end else if (state_next != XFER) begin
        ext_req <= 1'b0;
        ext_we  <= 1'b0;
      end
      if (finish_ok && !req_write) data_out <= load_ext;
    end
  end

`ifdef BYTE_BUS_ACK_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt;

  // counts XFER cycles spent waiting on the current byte
  always_ff @(posedge clk) begin
    if (reset || start_xfer || advance)
      wait_cnt <= '0;
    else if ((state == XFER) && !ext_ack && !ext_err)
      wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_byte_bus_adapter.sv
// Directed bench for byte_bus_adapter with a combinational byte-wide slave model.
// Covers the BYTE_BUS_ACK_TIMEOUT_EN build as well as the default one.
module tb_byte_bus_adapter;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  logic        clk = 1'b0;
  logic        reset, enable, is_write, is_unsigned;
  logic [1:0]  size;
  logic [31:0] addr, data_in, data_out;
  logic        busy, op_fault, addr_fault, access_fault;
  logic [31:0] ext_addr;
  logic [7:0]  ext_wdata, ext_rdata;
  logic        ext_req, ext_we, ext_ack, ext_err;

  logic        ack_on, err_on;
  logic [31:0] err_addr;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] log_addr[$];
  logic [7:0]  log_wdata[$];
  logic        log_we[$];

  logic [2:0]  r_faults, r_post;
  logic [31:0] r_dout;
  logic        stall_ok;

  always #5 clk = ~clk;

  byte_bus_adapter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .is_write(is_write),
    .is_unsigned(is_unsigned), .size(size), .addr(addr), .data_in(data_in),
    .data_out(data_out), .busy(busy), .op_fault(op_fault), .addr_fault(addr_fault),
    .access_fault(access_fault), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_rdata(ext_rdata),
    .ext_ack(ext_ack), .ext_err(ext_err)
  );

  function automatic logic [7:0] slave_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h78;
      32'h0000_0101: return 8'h56;
      32'h0000_0102: return 8'h34;
      32'h0000_0103: return 8'hF2;
      32'h0000_0007: return 8'h80;
      default:       return 8'hA5;
    endcase
  endfunction

  assign ext_rdata = slave_byte(ext_addr);
  assign ext_ack   = ext_req & ack_on;
  assign ext_err   = ext_req & err_on & (ext_addr == err_addr);

  always @(negedge clk) begin
    if (ext_req) begin
      log_addr.push_back(ext_addr);
      log_wdata.push_back(ext_wdata);
      log_we.push_back(ext_we);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // present one request from a negedge, wait for busy to drop, then idle one cycle
  task automatic do_access(input logic w, input logic u, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
    int cyc;
    log_addr.delete();
    log_wdata.delete();
    log_we.delete();
    enable = 1'b1; is_write = w; is_unsigned = u; size = sz; addr = a; data_in = d;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (busy && cyc < 64);
    if (busy) check("busy_bound", 32'(busy), 32'd0);
    r_faults = {op_fault, addr_fault, access_fault};
    r_dout   = data_out;
    enable   = 1'b0;
    @(negedge clk);
    r_post   = {op_fault, addr_fault, access_fault};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b0; is_write = 1'b0; is_unsigned = 1'b0;
    size = SZ_B; addr = 32'd0; data_in = 32'd0;
    ack_on = 1'b1; err_on = 1'b0; err_addr = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_req",    32'(ext_req), 32'd0);
    check("rst_we",     32'(ext_we), 32'd0);
    check("rst_addr",   ext_addr, 32'd0);
    check("rst_wdata",  32'(ext_wdata), 32'd0);
    check("rst_dout",   data_out, 32'd0);
    check("rst_faults", 32'({op_fault, addr_fault, access_fault}), 32'd0);

    // request presented in the same cycle reset drops
    reset = 1'b0;
    do_access(1'b0, 1'b0, SZ_W, 32'h100, 32'd0);
    check("wl_count",  32'(log_addr.size()), 32'd4);
    check("wl_addr0",  log_addr[0], 32'h100);
    check("wl_addr3",  log_addr[3], 32'h103);
    check("wl_we",     32'(log_we[0] | log_we[3]), 32'd0);
    check("wl_dout",   r_dout, 32'hF234_5678);
    check("wl_faults", 32'(r_faults), 32'd0);

    do_access(1'b0, 1'b0, SZ_B, 32'h7, 32'd0);
    check("bl_s_count", 32'(log_addr.size()), 32'd1);
    check("bl_s_addr",  log_addr[0], 32'h7);
    check("bl_s_dout",  r_dout, 32'hFFFF_FF80);
    do_access(1'b0, 1'b1, SZ_B, 32'h7, 32'd0);
    check("bl_u_dout",  r_dout, 32'h0000_0080);

    do_access(1'b1, 1'b0, SZ_H, 32'h202, 32'hAABB_CCDD);
    check("hs_count",  32'(log_addr.size()), 32'd2);
    check("hs_addr0",  log_addr[0], 32'h202);
    check("hs_wdata0", 32'(log_wdata[0]), 32'hDD);
    check("hs_addr1",  log_addr[1], 32'h203);
    check("hs_wdata1", 32'(log_wdata[1]), 32'hCC);
    check("hs_we",     32'(log_we[0] & log_we[1]), 32'd1);
    check("hs_dout",   r_dout, 32'h0000_0080);

    do_access(1'b0, 1'b0, SZ_H, 32'h102, 32'd0);
    check("hl_s_dout", r_dout, 32'hFFFF_F234);
    do_access(1'b0, 1'b1, SZ_H, 32'h102, 32'd0);
    check("hl_u_dout", r_dout, 32'h0000_F234);

    do_access(1'b0, 1'b0, SZ_W, 32'h102, 32'd0);
    check("mis_faults", 32'(r_faults), 32'b010);
    check("mis_count",  32'(log_addr.size()), 32'd0);
    check("mis_post",   32'(r_post), 32'd0);
    check("mis_dout",   r_dout, 32'h0000_F234);

    do_access(1'b0, 1'b0, SZ_X, 32'h100, 32'd0);
    check("op_faults", 32'(r_faults), 32'b100);
    check("op_count",  32'(log_addr.size()), 32'd0);
    check("op_post",   32'(r_post), 32'd0);

    // error on byte 1 while ack is also high: error wins
    err_on = 1'b1; err_addr = 32'h101;
    do_access(1'b0, 1'b0, SZ_W, 32'h100, 32'd0);
    err_on = 1'b0;
    check("err_faults", 32'(r_faults), 32'b001);
    check("err_count",  32'(log_addr.size()), 32'd2);
    check("err_last",   log_addr[log_addr.size() - 1], 32'h101);
    check("err_post",   32'(r_post), 32'd0);
    check("err_dout",   r_dout, 32'h0000_F234);

    do_access(1'b1, 1'b0, SZ_H, 32'hFFFF_FFFE, 32'h0000_1234);
    check("wrap_addr1",  log_addr[1], 32'hFFFF_FFFF);
    check("wrap_wdata1", 32'(log_wdata[1]), 32'h12);

    ack_on = 1'b0;
`ifdef BYTE_BUS_ACK_TIMEOUT_EN
    do_access(1'b0, 1'b0, SZ_W, 32'h100, 32'd0);
    check("to_faults", 32'(r_faults), 32'b001);
    check("to_count",  32'(log_addr.size()), 32'd16);
    check("to_dout",   r_dout, 32'h0000_F234);
`else
    enable = 1'b1; is_write = 1'b0; size = SZ_W; addr = 32'h100;
    stall_ok = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (!busy || !ext_req) stall_ok = 1'b0;
    end
    check("stall_busy", 32'(stall_ok), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check("abort_req",    32'(ext_req), 32'd0);
    check("abort_busy",   32'(busy), 32'd0);
    check("abort_faults", 32'({op_fault, addr_fault, access_fault}), 32'd0);
    check("abort_dout",   data_out, 32'h0000_F234);
`endif

    // reset mid-XFER with enable still asserted
    @(negedge clk);
    enable = 1'b1; is_write = 1'b0; size = SZ_W; addr = 32'h100;
    repeat (3) @(negedge clk);
    check("mid_pre_req", 32'(ext_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_req",  32'(ext_req), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_addr", ext_addr, 32'd0);
    check("mid_dout", data_out, 32'd0);
    reset = 1'b0; enable = 1'b0; ack_on = 1'b1;
    @(negedge clk);
    do_access(1'b0, 1'b1, SZ_B, 32'h7, 32'd0);
    check("post_rst_dout", r_dout, 32'h0000_0080);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
